// File: rtl/uart_param_xcvr.sv
// uart_param_xcvr: parametrised full-duplex UART transceiver.
// Independent TX/RX FSMs, optional parity, 1/2 stop bits, loopback.
module uart_param_xcvr #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 loopback,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] HALF_SMP  = CW'(CLKS_PER_BIT / 2 - 2);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic          SB_LAST   = (STOP_BITS == 2);
  localparam logic          PAR_EN    = (PARITY != 0);
  localparam logic          PAR_ODD   = (PARITY == 2);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP,
    RX_WAIT
  } rx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shr_q, tx_shr_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_sidx_q, tx_sidx_d;
  logic                 tx_out_q, tx_out_d;
  logic                 tx_tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shr_q   <= '0;
      tx_par_q   <= 1'b0;
      tx_sidx_q  <= 1'b0;
      tx_out_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shr_q   <= tx_shr_d;
      tx_par_q   <= tx_par_d;
      tx_sidx_q  <= tx_sidx_d;
      tx_out_q   <= tx_out_d;
    end
  end

  assign tx_tick = (tx_cnt_q == BIT_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shr_d   = tx_shr_q;
    tx_par_d   = tx_par_q;
    tx_sidx_d  = tx_sidx_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_state_d = TX_START;
          tx_shr_d   = tx_data;
          tx_par_d   = (^tx_data) ^ PAR_ODD;
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_sidx_d  = 1'b0;
        end
      end
      TX_START: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_tick) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
        end
      end
      TX_DATA: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_tick) begin
          tx_cnt_d = '0;
          tx_shr_d = tx_shr_q >> 1;
          tx_idx_d = tx_idx_q + 1'b1;
          if (tx_idx_q == DATA_LAST)
            tx_state_d = PAR_EN ? TX_PAR : TX_STOP;
        end
      end
      TX_PAR: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_tick) begin
          tx_state_d = TX_STOP;
          tx_cnt_d   = '0;
        end
      end
      TX_STOP: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        // the IDLE cycle is the final stop cycle, so frames abut
        if (tx_sidx_q == SB_LAST && tx_cnt_q == STOP_LAST) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
        end else if (tx_tick) begin
          tx_cnt_d  = '0;
          tx_sidx_d = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_out_d = 1'b1;
    unique case (tx_state_d)
      TX_START: tx_out_d = 1'b0;
      TX_DATA:  tx_out_d = tx_shr_d[0];
      TX_PAR:   tx_out_d = tx_par_d;
      default:  tx_out_d = 1'b1;
    endcase
  end

  assign tx_ready = (tx_state_q == TX_IDLE);
  assign tx_out   = tx_out_q;

  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shr_q, rx_shr_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_sidx_q, rx_sidx_d;
  logic                 rx_facc_q, rx_facc_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_sel, rx_tick;

  assign rx_sel = loopback ? tx_out_q : rx_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shr_q   <= '0;
      rx_par_q   <= 1'b0;
      rx_sidx_q  <= 1'b0;
      rx_facc_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      sync1_q    <= rx_sel;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shr_q   <= rx_shr_d;
      rx_par_q   <= rx_par_d;
      rx_sidx_q  <= rx_sidx_d;
      rx_facc_q  <= rx_facc_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign rx_tick = (rx_cnt_q == BIT_LAST);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shr_d   = rx_shr_q;
    rx_par_d   = rx_par_q;
    rx_sidx_d  = rx_sidx_q;
    rx_facc_d  = rx_facc_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        // sampling here accepts a low pulse of CLKS_PER_BIT/2
        if (rx_cnt_q == HALF_SMP) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_tick) begin
          rx_cnt_d = '0;
          rx_shr_d = {sync2_q, rx_shr_q[DATA_BITS-1:1]};
          rx_idx_d = rx_idx_q + 1'b1;
          if (rx_idx_q == DATA_LAST) begin
            rx_state_d = PAR_EN ? RX_PAR : RX_STOP;
            rx_sidx_d  = 1'b0;
            rx_facc_d  = 1'b0;
          end
        end
      end
      RX_PAR: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_par_d   = sync2_q;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_tick) begin
          rx_cnt_d  = '0;
          rx_sidx_d = 1'b1;
          rx_facc_d = rx_facc_q | ~sync2_q;
          if (rx_sidx_q == SB_LAST)
            rx_state_d = rx_facc_d ? RX_WAIT : RX_IDLE;
        end
      end
      RX_WAIT: begin
        if (sync2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    if (rx_state_q == RX_STOP && rx_tick &&
        rx_sidx_q == SB_LAST) begin
      rx_valid_d = 1'b1;
      rx_data_d  = rx_shr_q;
      rx_perr_d  = PAR_EN &&
                   (rx_par_q != ((^rx_shr_q) ^ PAR_ODD));
      rx_ferr_d  = rx_facc_q | ~sync2_q;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_param_xcvr.sv
// tb_uart_param_xcvr: directed checks on 8N1, 8E1 loopback
// and 7O2 instances of uart_param_xcvr.
module tb_uart_param_xcvr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       lb_a, tx_valid_a, rx_in_a;
  logic [7:0] tx_data_a;
  logic       tx_ready_a, tx_out_a;
  logic [7:0] rx_data_a;
  logic       rx_valid_a, rx_pe_a, rx_fe_a;

  logic       lb_b, tx_valid_b, rx_in_b;
  logic [7:0] tx_data_b;
  logic       tx_ready_b, tx_out_b;
  logic [7:0] rx_data_b;
  logic       rx_valid_b, rx_pe_b, rx_fe_b;

  logic       lb_c, tx_valid_c, rx_in_c;
  logic [6:0] tx_data_c;
  logic       tx_ready_c, tx_out_c;
  logic [6:0] rx_data_c;
  logic       rx_valid_c, rx_pe_c, rx_fe_c;

  uart_param_xcvr #(
    .DATA_BITS(8), .CLKS_PER_BIT(16),
    .PARITY(0), .STOP_BITS(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .loopback(lb_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .tx_out(tx_out_a),
    .rx_in(rx_in_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .rx_parity_err(rx_pe_a),
    .rx_frame_err(rx_fe_a)
  );

  uart_param_xcvr #(
    .DATA_BITS(8), .CLKS_PER_BIT(16),
    .PARITY(1), .STOP_BITS(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .loopback(lb_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .tx_out(tx_out_b),
    .rx_in(rx_in_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .rx_parity_err(rx_pe_b),
    .rx_frame_err(rx_fe_b)
  );

  uart_param_xcvr #(
    .DATA_BITS(7), .CLKS_PER_BIT(16),
    .PARITY(2), .STOP_BITS(2)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .loopback(lb_c),
    .tx_data(tx_data_c), .tx_valid(tx_valid_c),
    .tx_ready(tx_ready_c), .tx_out(tx_out_c),
    .rx_in(rx_in_c), .rx_data(rx_data_c),
    .rx_valid(rx_valid_c), .rx_parity_err(rx_pe_c),
    .rx_frame_err(rx_fe_c)
  );

  typedef struct {
    int         cyc;
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  ev_t qc[$];
  int  cyc;
  int  n_run;
  int  n_fail;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rx_valid_a)
      qa.push_back('{cyc, 9'(rx_data_a), rx_pe_a, rx_fe_a});
    if (rx_valid_b)
      qb.push_back('{cyc, 9'(rx_data_b), rx_pe_b, rx_fe_b});
    if (rx_valid_c)
      qc.push_back('{cyc, 9'(rx_data_c), rx_pe_c, rx_fe_c});
  endtask

  task automatic drive_a(input logic [15:0] bits,
                         input int nb);
    for (int i = 0; i < nb; i++) begin
      rx_in_a = bits[i];
      repeat (16) tick();
    end
  endtask

  task automatic drive_c(input logic [15:0] bits,
                         input int nb);
    for (int i = 0; i < nb; i++) begin
      rx_in_c = bits[i];
      repeat (16) tick();
    end
  endtask

  task automatic tx_frame_a(input logic [7:0] d);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    tx_data_a  = d;
    tx_valid_a = 1'b1;
    tick();
    tx_valid_a = 1'b0;
    for (int k = 0; k < 160; k++) begin
      chk($sformatf("txa_%0h_out_%0d", d, k),
          32'(tx_out_a), 32'(f[k/16]));
      chk($sformatf("txa_%0h_rdy_%0d", d, k),
          32'(tx_ready_a), 32'(k == 159));
      tick();
    end
    chk($sformatf("txa_%0h_rdy_end", d),
        32'(tx_ready_a), 32'd1);
  endtask

  initial begin
    int t0;
    logic [10:0] f0;
    logic [10:0] f1;
    logic exp_out;
    cyc = 0;
    n_run = 0;
    n_fail = 0;
    rst_n = 1'b0;
    lb_a = 1'b0; tx_valid_a = 1'b0;
    tx_data_a = '0; rx_in_a = 1'b1;
    lb_b = 1'b1; tx_valid_b = 1'b0;
    tx_data_b = '0; rx_in_b = 1'b1;
    lb_c = 1'b0; tx_valid_c = 1'b0;
    tx_data_c = '0; rx_in_c = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_tx_out", 32'(tx_out_a), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready_a), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid_a), 32'd0);
    chk("rst_rx_data", 32'(rx_data_a), 32'd0);
    chk("rst_rx_pe", 32'(rx_pe_a), 32'd0);
    chk("rst_rx_fe", 32'(rx_fe_a), 32'd0);
    chk("rst_b_tx_out", 32'(tx_out_b), 32'd1);
    chk("rst_c_tx_ready", 32'(tx_ready_c), 32'd1);
    chk("rst_c_tx_out", 32'(tx_out_c), 32'd1);
    chk("rst_c_rx_data", 32'(rx_data_c), 32'd0);

    tx_frame_a(8'hA5);

    // 8E1 loopback, two words back to back
    qb.delete();
    f0 = {1'b1, 1'b0, 8'h3C, 1'b0};
    f1 = {1'b1, 1'b0, 8'hC3, 1'b0};
    tx_data_b  = 8'h3C;
    tx_valid_b = 1'b1;
    tick();
    t0 = cyc;
    tx_data_b = 8'hC3;
    for (int k = 0; k < 452; k++) begin
      if (k == 176) tx_valid_b = 1'b0;
      if (k < 176) exp_out = f0[k/16];
      else if (k < 352) exp_out = f1[(k-176)/16];
      else exp_out = 1'b1;
      chk($sformatf("lb_out_%0d", k),
          32'(tx_out_b), 32'(exp_out));
      chk($sformatf("lb_rdy_%0d", k), 32'(tx_ready_b),
          32'(k == 175 || k >= 351));
      tick();
    end
    chk("lb_count", 32'(qb.size()), 32'd2);
    if (qb.size() == 2) begin
      chk("lb_lat0", 32'(qb[0].cyc - t0), 32'd170);
      chk("lb_gap", 32'(qb[1].cyc - qb[0].cyc), 32'd176);
      chk("lb_data0", 32'(qb[0].data), 32'h3C);
      chk("lb_data1", 32'(qb[1].data), 32'hC3);
      chk("lb_pe0", 32'(qb[0].pe), 32'd0);
      chk("lb_fe0", 32'(qb[0].fe), 32'd0);
      chk("lb_pe1", 32'(qb[1].pe), 32'd0);
      chk("lb_fe1", 32'(qb[1].fe), 32'd0);
    end

    // 7O2: 0x55 with wrong parity, then 0x2A with correct parity
    qc.delete();
    t0 = cyc;
    drive_c({1'b1, 1'b1, 1'b0, 7'h55, 1'b0}, 11);
    repeat (20) tick();
    chk("o2_count", 32'(qc.size()), 32'd1);
    if (qc.size() == 1) begin
      chk("o2_lat", 32'(qc[0].cyc - t0), 32'd170);
      chk("o2_data", 32'(qc[0].data), 32'h55);
      chk("o2_pe", 32'(qc[0].pe), 32'd1);
      chk("o2_fe", 32'(qc[0].fe), 32'd0);
    end
    drive_c({1'b1, 1'b1, 1'b0, 7'h2A, 1'b0}, 11);
    repeat (20) tick();
    chk("o2b_count", 32'(qc.size()), 32'd2);
    if (qc.size() == 2) begin
      chk("o2b_data", 32'(qc[1].data), 32'h2A);
      chk("o2b_pe", 32'(qc[1].pe), 32'd0);
      chk("o2b_fe", 32'(qc[1].fe), 32'd0);
    end

    // 8N1 0x0F with low stop bit, line held low
    qa.delete();
    t0 = cyc;
    drive_a({1'b0, 8'h0F, 1'b0}, 10);
    rx_in_a = 1'b0;
    repeat (40 * 16) tick();
    chk("brk_count", 32'(qa.size()), 32'd1);
    if (qa.size() == 1) begin
      chk("brk_lat", 32'(qa[0].cyc - t0), 32'd154);
      chk("brk_data", 32'(qa[0].data), 32'h0F);
      chk("brk_fe", 32'(qa[0].fe), 32'd1);
      chk("brk_pe", 32'(qa[0].pe), 32'd0);
    end
    rx_in_a = 1'b1;
    repeat (32) tick();
    chk("brk_quiet", 32'(qa.size()), 32'd1);
    drive_a({1'b1, 8'h5A, 1'b0}, 10);
    repeat (20) tick();
    chk("brk_next_count", 32'(qa.size()), 32'd2);
    if (qa.size() == 2) begin
      chk("brk_next_data", 32'(qa[1].data), 32'h5A);
      chk("brk_next_fe", 32'(qa[1].fe), 32'd0);
    end

    // 3-cycle glitch, then a clean 0x81
    qa.delete();
    rx_in_a = 1'b0;
    repeat (3) tick();
    rx_in_a = 1'b1;
    repeat (48) tick();
    chk("glitch_none", 32'(qa.size()), 32'd0);
    drive_a({1'b1, 8'h81, 1'b0}, 10);
    repeat (20) tick();
    chk("glitch_count", 32'(qa.size()), 32'd1);
    if (qa.size() == 1) begin
      chk("glitch_data", 32'(qa[0].data), 32'h81);
      chk("glitch_fe", 32'(qa[0].fe), 32'd0);
      chk("glitch_pe", 32'(qa[0].pe), 32'd0);
    end
    chk("rx_data_hold", 32'(rx_data_a), 32'h81);

    // reset in the middle of a 0xFF transmission
    qb.delete();
    tx_data_a  = 8'hFF;
    tx_valid_a = 1'b1;
    tx_data_b  = 8'hFF;
    tx_valid_b = 1'b1;
    tick();
    tx_valid_a = 1'b0;
    tx_valid_b = 1'b0;
    repeat (80) tick();
    chk("mid_busy", 32'(tx_ready_a), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_tx_out", 32'(tx_out_a), 32'd1);
    chk("abort_tx_ready", 32'(tx_ready_a), 32'd1);
    chk("abort_b_ready", 32'(tx_ready_b), 32'd1);
    chk("abort_rx_data", 32'(rx_data_a), 32'd0);
    repeat (200) tick();
    chk("abort_no_rx", 32'(qb.size()), 32'd0);
    chk("abort_idle_out", 32'(tx_out_a), 32'd1);
    tx_frame_a(8'h12);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
